// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia_if: controller/ROM-side signals of the sequence playback block.
interface exibe_sequencia_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4
);
   logic                  iniciar;
   logic [ADDR_WIDTH-1:0] limite;
   logic [DATA_WIDTH-1:0] dado_memoria;
   logic [ADDR_WIDTH-1:0] endereco;
   logic [DATA_WIDTH-1:0] leds;
   logic                  ativo;
   logic                  pronto;
   logic [3:0]            db_estado;
   modport master (
      output iniciar, limite, dado_memoria,
      input  endereco, leds, ativo, pronto, db_estado
   );
   modport slave (
      input  iniciar, limite, dado_memoria,
      output endereco, leds, ativo, pronto, db_estado
   );
endinterface

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays ROM entries 0..limite on leds, each lit T_ACESO cycles then blank T_APAGADO cycles.
module exibe_sequencia #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4,
   parameter int T_ACESO    = 500,
   parameter int T_APAGADO  = 250
) (
   input logic clock,
   input logic reset,
   exibe_sequencia_if.slave bus
);
   localparam int T_MAX = T_ACESO > T_APAGADO ? T_ACESO : T_APAGADO;
   localparam int TW    = T_MAX > 1 ? $clog2(T_MAX) : 1;
   typedef enum logic [3:0] {
      INICIAL = 4'h0,
      PREPARA = 4'h1,
      CARREGA = 4'h2,
      ACENDE  = 4'h3,
      APAGA   = 4'h4,
      PROXIMO = 4'h5,
      FIM     = 4'hF
   } state_t;
   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] endereco, endereco_n, lim, lim_n;
   logic [DATA_WIDTH-1:0] leds, leds_n;
   logic [TW-1:0]         timer, timer_n;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state    <= INICIAL;
         endereco <= '0;
         leds     <= '0;
         timer    <= '0;
         lim      <= '0;
      end else begin
         state    <= state_n;
         endereco <= endereco_n;
         leds     <= leds_n;
         timer    <= timer_n;
         lim      <= lim_n;
      end
   // Last-entry compare happens in APAGA, before PROXIMO increments, so endereco never wraps.
   always_comb begin
      state_n    = state;
      endereco_n = endereco;
      leds_n     = leds;
      timer_n    = timer;
      lim_n      = lim;
      case (state)
         INICIAL: if (bus.iniciar) begin
            lim_n   = bus.limite;
            state_n = PREPARA;
         end
         PREPARA: begin
            endereco_n = '0;
            timer_n    = '0;
            state_n    = CARREGA;
         end
         CARREGA: begin
            leds_n  = bus.dado_memoria;
            state_n = ACENDE;
         end
         ACENDE: if (timer == TW'(T_ACESO - 1)) begin
            timer_n = '0;
            leds_n  = '0;
            state_n = APAGA;
         end else timer_n = timer + 1'b1;
         APAGA: if (timer == TW'(T_APAGADO - 1)) begin
            timer_n = '0;
            state_n = endereco == lim ? FIM : PROXIMO;
         end else timer_n = timer + 1'b1;
         PROXIMO: begin
            endereco_n = endereco + 1'b1;
            state_n    = CARREGA;
         end
         FIM: begin
            leds_n  = '0;
            state_n = INICIAL;
         end
         default: begin
            leds_n  = '0;
            state_n = INICIAL;
         end
      endcase
   end
   assign bus.endereco  = endereco;
   assign bus.leds      = leds;
   assign bus.ativo     = state inside {PREPARA, CARREGA, ACENDE, APAGA, PROXIMO};
   assign bus.pronto    = state == FIM;
   assign bus.db_estado = state;
endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia: directed scenarios for exibe_sequencia with T_ACESO=4, T_APAGADO=2, ROM entry i = i+1.
module tb_exibe_sequencia;
   logic clock = 0;
   logic reset = 1;
   logic [3:0] rom_xor = 0;
   int tests = 0;
   int fails = 0;
   logic [3:0] tr_leds[$], tr_end[$], exp_leds[$], exp_end[$];
   bit tr_ativo[$];
   bit timed_out;

   exibe_sequencia_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus();
   exibe_sequencia #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .T_ACESO(4), .T_APAGADO(2)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;
   assign bus.dado_memoria = (bus.endereco + 4'd1) ^ rom_xor;

   // Expected per-cycle trace from the first PREPARA cycle through FIM.
   function automatic void build(input int n);
      exp_leds = {};
      exp_end = {};
      exp_leds.push_back(4'd0); exp_end.push_back(4'd0);
      for (int i = 0; i < n; i++) begin
         exp_leds.push_back(4'd0); exp_end.push_back(4'(i));
         repeat (4) begin exp_leds.push_back(4'(i + 1)); exp_end.push_back(4'(i)); end
         repeat (2) begin exp_leds.push_back(4'd0); exp_end.push_back(4'(i)); end
         if (i < n - 1) begin exp_leds.push_back(4'd0); exp_end.push_back(4'(i)); end
      end
      exp_leds.push_back(4'd0); exp_end.push_back(4'(n - 1));
   endfunction

   task automatic play(input logic [3:0] lim, input bit disturb);
      int stage = 0;
      bit got = 0;
      tr_leds = {}; tr_end = {}; tr_ativo = {};
      @(negedge clock);
      bus.limite = lim;
      bus.iniciar = 1;
      @(negedge clock);
      bus.iniciar = 0;
      for (int c = 0; c < 400; c++) begin
         tr_leds.push_back(bus.leds);
         tr_end.push_back(bus.endereco);
         tr_ativo.push_back(bus.ativo);
         if (stage == 1) begin bus.iniciar = 0; rom_xor = 0; stage = 2; end
         if (disturb && stage == 0 && bus.db_estado == 4'h3 && bus.endereco == 4'd1) begin
            bus.limite = 0; bus.iniciar = 1; rom_xor = 4'hF; stage = 1;
         end
         if (bus.pronto) begin got = 1; break; end
         @(negedge clock);
      end
      timed_out = !got;
   endtask

   task automatic test_reset;
      bus.iniciar = 0;
      bus.limite = 0;
      #2 reset = 0;
      repeat (2) @(negedge clock);
      tests++;
      if ({bus.leds, bus.endereco, bus.ativo, bus.pronto, bus.db_estado} !== 14'h0)
         $display("FAIL reset_hold: leds=%h end=%h ativo=%b pronto=%b est=%h, want all 0",
                  bus.leds, bus.endereco, bus.ativo, bus.pronto, bus.db_estado);
      reset = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         tests++;
         if ({bus.leds, bus.endereco, bus.ativo, bus.pronto, bus.db_estado} !== 14'h0) begin
            fails++;
            $display("FAIL idle_c%0d: leds=%h end=%h ativo=%b pronto=%b est=%h, want all 0",
                     c, bus.leds, bus.endereco, bus.ativo, bus.pronto, bus.db_estado);
         end
      end
   endtask

   task automatic test_single;
      int bad = 0;
      int act = 0;
      play(4'd0, 0);
      build(1);
      tests++;
      if (timed_out) begin fails++; $display("FAIL single_timeout: no pronto within 400 cycles"); end
      tests++;
      if (tr_leds.size() !== 9) begin
         fails++; $display("FAIL single_pronto_cycle: got %0d, want 9", tr_leds.size());
      end
      for (int i = 0; i < tr_leds.size() && i < exp_leds.size(); i++)
         if (tr_leds[i] !== exp_leds[i]) bad++;
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL single_leds: %0d cycles differ, want 0", bad); end
      foreach (tr_ativo[i]) act += int'(tr_ativo[i]);
      tests++;
      if (act !== 8) begin fails++; $display("FAIL single_ativo: %0d cycles high, want 8", act); end
   endtask

   task automatic test_three;
      int bad_l = 0;
      int bad_e = 0;
      int act = 0;
      logic [3:0] mx = 0;
      play(4'd2, 0);
      build(3);
      tests++;
      if (timed_out || tr_leds.size() !== 25) begin
         fails++; $display("FAIL three_pronto_cycle: got %0d (timeout=%b), want 25", tr_leds.size(), timed_out);
      end
      for (int i = 0; i < tr_leds.size() && i < exp_leds.size(); i++) begin
         if (tr_leds[i] !== exp_leds[i]) bad_l++;
         if (i > 0 && tr_end[i] !== exp_end[i]) bad_e++;
         if (i > 0 && tr_end[i] > mx) mx = tr_end[i];
      end
      tests++;
      if (bad_l !== 0) begin fails++; $display("FAIL three_leds: %0d cycles differ, want 0", bad_l); end
      tests++;
      if (bad_e !== 0) begin fails++; $display("FAIL three_endereco: %0d cycles differ, want 0", bad_e); end
      tests++;
      if (mx !== 4'd2) begin fails++; $display("FAIL three_end_max: got %0d, want 2", mx); end
      foreach (tr_ativo[i]) act += int'(tr_ativo[i]);
      tests++;
      if (act !== 24) begin fails++; $display("FAIL three_ativo: %0d cycles high, want 24", act); end
   endtask

   task automatic test_wrap;
      int bad_l = 0;
      int bad_e = 0;
      play(4'd15, 0);
      build(16);
      tests++;
      if (timed_out || tr_leds.size() !== 129) begin
         fails++; $display("FAIL wrap_pronto_cycle: got %0d (timeout=%b), want 129", tr_leds.size(), timed_out);
      end
      for (int i = 0; i < tr_leds.size() && i < exp_leds.size(); i++) begin
         if (tr_leds[i] !== exp_leds[i]) bad_l++;
         if (i > 0 && tr_end[i] !== exp_end[i]) bad_e++;
      end
      tests++;
      if (bad_l !== 0) begin fails++; $display("FAIL wrap_leds: %0d cycles differ, want 0", bad_l); end
      tests++;
      if (bad_e !== 0) begin fails++; $display("FAIL wrap_endereco: %0d cycles differ, want 0", bad_e); end
      tests++;
      if (bus.endereco !== 4'd15) begin fails++; $display("FAIL wrap_end_final: got %0d, want 15", bus.endereco); end
   endtask

   task automatic test_disturb;
      int bad = 0;
      play(4'd2, 1);
      build(3);
      tests++;
      if (timed_out || tr_leds.size() !== 25) begin
         fails++; $display("FAIL disturb_pronto_cycle: got %0d (timeout=%b), want 25", tr_leds.size(), timed_out);
      end
      for (int i = 0; i < tr_leds.size() && i < exp_leds.size(); i++)
         if (tr_leds[i] !== exp_leds[i]) bad++;
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL disturb_leds: %0d cycles differ, want 0", bad); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         tests++;
         if (bus.db_estado !== 4'h0 || bus.pronto !== 1'b0) begin
            fails++; $display("FAIL disturb_idle_c%0d: est=%h pronto=%b, want 0 0", c, bus.db_estado, bus.pronto);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit got = 0;
      bus.limite = 0;
      bus.iniciar = 1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (bus.pronto) begin got = 1; break; end
      end
      tests++;
      if (!got) begin fails++; $display("FAIL b2b_first_pronto: none within 30 cycles, want 1"); end
      @(negedge clock);
      tests++;
      if (bus.db_estado !== 4'h0) begin fails++; $display("FAIL b2b_inicial: est=%h, want 0", bus.db_estado); end
      @(negedge clock);
      tests++;
      if (bus.db_estado !== 4'h1) begin fails++; $display("FAIL b2b_restart: est=%h, want 1", bus.db_estado); end
      bus.iniciar = 0;
      got = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (bus.pronto) begin got = 1; break; end
      end
      tests++;
      if (!got) begin fails++; $display("FAIL b2b_second_pronto: none within 30 cycles, want 1"); end
   endtask

   task automatic test_mid_reset;
      bit got = 0;
      int bad = 0;
      @(negedge clock);
      bus.limite = 2;
      bus.iniciar = 1;
      @(negedge clock);
      bus.iniciar = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.db_estado == 4'h3) begin got = 1; break; end
         @(negedge clock);
      end
      tests++;
      if (!got) begin fails++; $display("FAIL midrst_reach_acende: not reached in 20 cycles"); end
      reset = 0;
      #1;
      tests++;
      if ({bus.leds, bus.ativo, bus.pronto, bus.db_estado} !== 10'h0) begin
         fails++; $display("FAIL midrst_abort: leds=%h ativo=%b pronto=%b est=%h, want all 0",
                           bus.leds, bus.ativo, bus.pronto, bus.db_estado);
      end
      @(negedge clock);
      reset = 1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (bus.pronto !== 1'b0 || bus.db_estado !== 4'h0) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL midrst_idle: %0d cycles not idle, want 0", bad); end
      play(4'd2, 0);
      build(3);
      bad = 0;
      for (int i = 0; i < tr_leds.size() && i < exp_leds.size(); i++)
         if (tr_leds[i] !== exp_leds[i]) bad++;
      tests++;
      if (timed_out || tr_leds.size() !== 25 || bad !== 0) begin
         fails++; $display("FAIL midrst_replay: len=%0d diffs=%0d, want 25 0", tr_leds.size(), bad);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_three;
      test_wrap;
      test_disturb;
      test_back_to_back;
      test_mid_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
